mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin burst arbiter between instruction and data ports onto one memory
module mem_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int BEAT_W    = $clog2(BURST_LEN)
) (
    input  logic        MEM_CLK,
    input  logic        MEM_RESET,

    input  logic        I_REQ,
    input  logic [29:0] I_ADDR,
    output logic [31:0] I_DOUT,
    output logic        I_VALID,
    output logic        I_DONE,

    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [29:0] D_ADDR,
    input  logic [31:0] D_DIN,
    output logic [31:0] D_DOUT,
    output logic        D_VALID,
    output logic        D_DONE,

    output logic [BEAT_W-1:0] BEAT,

    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic [29:0] MEM_ADDR,
    output logic [31:0] MEM_DATA_IN,
    input  logic [31:0] MEM_DOUT,
    input  logic        memValid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BURST = 2'd1,
        D_BURST = 2'd2
    } state_t;

    localparam int                BASE_W    = 30 - BEAT_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic              GNT_I     = 1'b0;
    localparam logic              GNT_D     = 1'b1;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                last_gnt_q, last_gnt_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic                we_q, we_d;

    logic                grant_i, grant_d;
    logic                in_i, in_d, at_last;

    // Burst-aligned addresses: the beat index supplies the low bits.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{I_ADDR[BEAT_W-1:0], D_ADDR[BEAT_W-1:0]};

    // D wins a tie unless it was the last port served.
    assign grant_d = D_REQ && (!I_REQ || (last_gnt_q == GNT_I));
    assign grant_i = I_REQ && !grant_d;

    always_ff @(posedge MEM_CLK) begin
        if (MEM_RESET) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            last_gnt_q <= GNT_I;
            base_q     <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            last_gnt_q <= last_gnt_d;
            base_q     <= base_d;
            we_q       <= we_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        last_gnt_d = last_gnt_q;
        base_d     = base_q;
        we_d       = we_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d    = D_BURST;
                    last_gnt_d = GNT_D;
                    base_d     = D_ADDR[29:BEAT_W];
                    we_d       = D_WE;
                    beat_d     = '0;
                end else if (grant_i) begin
                    state_d    = I_BURST;
                    last_gnt_d = GNT_I;
                    base_d     = I_ADDR[29:BEAT_W];
                    we_d       = 1'b0;
                    beat_d     = '0;
                end
            end
            I_BURST, D_BURST: begin
                // Memory may stall indefinitely; only a completed word advances the beat.
                if (memValid) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    assign in_i    = (state_q == I_BURST);
    assign in_d    = (state_q == D_BURST);
    assign at_last = (beat_q == LAST_BEAT);

    assign MEM_ADDR    = (in_i || in_d) ? {base_q, beat_q} : 30'd0;
    assign MEM_RE      = in_i || (in_d && !we_q);
    assign MEM_WE      = in_d && we_q;
    assign MEM_DATA_IN = D_DIN;

    assign I_VALID = memValid && in_i;
    assign D_VALID = memValid && in_d;
    assign I_DONE  = I_VALID && at_last;
    assign D_DONE  = D_VALID && at_last;
    assign I_DOUT  = MEM_DOUT;
    assign D_DOUT  = MEM_DOUT;
    assign BEAT    = beat_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a stalling word-memory model
module tb_mem_arbiter;

    logic        MEM_CLK = 1'b0;
    logic        MEM_RESET = 1'b1;
    logic        I_REQ = 1'b0, D_REQ = 1'b0, D_WE = 1'b0, memValid = 1'b0;
    logic [29:0] I_ADDR = '0, D_ADDR = '0, MEM_ADDR;
    logic [31:0] D_DIN = '0, MEM_DOUT = '0, I_DOUT, D_DOUT, MEM_DATA_IN;
    logic        I_VALID, I_DONE, D_VALID, D_DONE, MEM_RE, MEM_WE;
    logic [2:0]  BEAT;

    mem_arbiter #(.BURST_LEN(8)) dut (
        .MEM_CLK(MEM_CLK), .MEM_RESET(MEM_RESET),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_DOUT(I_DOUT), .I_VALID(I_VALID), .I_DONE(I_DONE),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_DIN(D_DIN), .D_DOUT(D_DOUT),
        .D_VALID(D_VALID), .D_DONE(D_DONE), .BEAT(BEAT),
        .MEM_RE(MEM_RE), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA_IN(MEM_DATA_IN),
        .MEM_DOUT(MEM_DOUT), .memValid(memValid)
    );

    always #5 MEM_CLK = ~MEM_CLK;

    localparam logic [31:0] IMG = 32'hC0DE_0000;

    logic [31:0] mem [0:255];
    int          delay = 0, wait_cnt = 0;
    bit          mv_force = 1'b0;

    int          n_total = 0, n_pass = 0;
    int          cyc = 0, req_cyc = 0;
    int          i_cnt, d_cnt, i_first, d_first, i_done_cyc, d_done_cyc, i_dones, d_dones;
    int          i_done_beat, d_done_beat, addr_err, data_err, hold_err, idle_err, stall_cyc;
    logic [29:0] i_base, d_base, prev_addr = '0;
    logic [31:0] i_exp [0:7];
    logic [31:0] d_exp [0:7];
    logic [2:0]  prev_beat = '0;
    logic        prev_active = 1'b0, prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: memory model reacts after the edge, then everything is observed mid-cycle.
    task automatic tick();
        logic active;
        @(posedge MEM_CLK);
        #1;
        if (mv_force) begin
            memValid = 1'b1;
        end else if (!(MEM_RE || MEM_WE)) begin
            memValid = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= delay) begin
            memValid = 1'b1;
            wait_cnt = 0;
        end else begin
            memValid = 1'b0;
            wait_cnt++;
        end
        MEM_DOUT = mem[MEM_ADDR[7:0]];
        D_DIN    = {29'd0, BEAT};
        @(negedge MEM_CLK);
        cyc++;
        active = MEM_RE || MEM_WE;
        if (MEM_WE && memValid) mem[MEM_ADDR[7:0]] = MEM_DATA_IN;
        if (active && !memValid) stall_cyc++;
        if (active && prev_active && !prev_valid && (MEM_ADDR !== prev_addr || BEAT !== prev_beat))
            hold_err++;
        if (!active && (I_VALID || D_VALID || BEAT !== 3'd0 || MEM_ADDR !== 30'd0)) idle_err++;
        if (I_VALID) begin
            if (i_cnt == 0) i_first = cyc;
            if (i_cnt < 8) begin
                if (MEM_ADDR !== i_base + 30'(i_cnt) || BEAT !== 3'(i_cnt)) addr_err++;
                if (I_DOUT !== i_exp[i_cnt]) data_err++;
            end
            i_cnt++;
        end
        if (D_VALID) begin
            if (d_cnt == 0) d_first = cyc;
            if (d_cnt < 8) begin
                if (MEM_ADDR !== d_base + 30'(d_cnt) || BEAT !== 3'(d_cnt)) addr_err++;
                if (!MEM_WE && D_DOUT !== d_exp[d_cnt]) data_err++;
            end
            d_cnt++;
        end
        if (I_DONE) begin i_dones++; i_done_cyc = cyc; i_done_beat = int'(BEAT); I_REQ = 1'b0; end
        if (D_DONE) begin d_dones++; d_done_cyc = cyc; d_done_beat = int'(BEAT); D_REQ = 1'b0; end
        prev_active = active;
        prev_valid  = memValid;
        prev_addr   = MEM_ADDR;
        prev_beat   = BEAT;
    endtask

    task automatic clear_stats();
        i_cnt = 0; d_cnt = 0; i_first = -1; d_first = -1; i_done_cyc = -1; d_done_cyc = -1;
        i_dones = 0; d_dones = 0; i_done_beat = -1; d_done_beat = -1;
        addr_err = 0; data_err = 0; hold_err = 0; idle_err = 0; stall_cyc = 0;
        req_cyc = cyc;
    endtask

    task automatic set_exp(input bit is_d, input logic [29:0] base, input bit image);
        for (int k = 0; k < 8; k++) begin
            if (is_d) d_exp[k] = image ? IMG + 32'(base) + 32'(k) : 32'(k);
            else      i_exp[k] = image ? IMG + 32'(base) + 32'(k) : 32'(k);
        end
        if (is_d) d_base = base; else i_base = base;
    endtask

    task automatic run_until_idle(input string tag);
        for (int n = 0; n < 400 && (I_REQ || D_REQ); n++) tick();
        check({tag, "_timeout"}, {31'd0, I_REQ || D_REQ}, 32'd0);
        tick();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = IMG + 32'(a);
        clear_stats();
        tick(); tick();
        check("rst_re",   {31'd0, MEM_RE},  32'd0);
        check("rst_we",   {31'd0, MEM_WE},  32'd0);
        check("rst_addr", {2'd0, MEM_ADDR}, 32'd0);
        check("rst_beat", {29'd0, BEAT},    32'd0);
        check("rst_vld",  {30'd0, I_VALID, D_VALID}, 32'd0);
        MEM_RESET = 1'b0;
        tick();

        // Tie straight out of reset: D first, I two edges after D_DONE.
        clear_stats();
        set_exp(1'b0, 30'h40, 1'b1);
        set_exp(1'b1, 30'h60, 1'b1);
        I_ADDR = 30'h40; D_ADDR = 30'h60; D_WE = 1'b0; I_REQ = 1'b1; D_REQ = 1'b1;
        run_until_idle("tie1");
        check("tie1_d_first", d_first, req_cyc + 1);
        check("tie1_d_done",  d_done_cyc, req_cyc + 8);
        check("tie1_i_gap",   i_first, d_done_cyc + 2);
        check("tie1_i_done",  i_done_cyc, req_cyc + 17);
        check("tie1_counts",  {i_cnt[15:0], d_cnt[15:0]}, {16'd8, 16'd8});
        check("tie1_errs",    addr_err + data_err + idle_err, 0);

        // D write burst at 0x23 lands at 0x20..0x27 with the beat index as data.
        clear_stats();
        d_base = 30'h20;
        D_ADDR = 30'h23; D_WE = 1'b1; D_REQ = 1'b1;
        run_until_idle("wr");
        check("wr_beats",    d_cnt, 8);
        check("wr_done",     d_done_cyc, req_cyc + 8);
        check("wr_done_beat", d_done_beat, 7);
        check("wr_addr_err", addr_err, 0);
        for (int k = 0; k < 8; k++) check($sformatf("wr_mem%0d", k), mem[8'h20 + k], 32'(k));

        clear_stats();
        set_exp(1'b1, 30'h20, 1'b0);
        D_ADDR = 30'h20; D_WE = 1'b0; D_REQ = 1'b1;
        run_until_idle("rd");
        check("rd_beats", d_cnt, 8);
        check("rd_data",  data_err, 0);
        check("rd_re_seen", i_cnt, 0);

        // Second tie after D was served last: I goes first.
        clear_stats();
        set_exp(1'b0, 30'h10, 1'b1);
        set_exp(1'b1, 30'h20, 1'b0);
        I_ADDR = 30'h10; D_ADDR = 30'h20; I_REQ = 1'b1; D_REQ = 1'b1;
        run_until_idle("tie2");
        check("tie2_i_first", i_first, req_cyc + 1);
        check("tie2_d_gap",   d_first, i_done_cyc + 2);
        check("tie2_errs",    addr_err + data_err, 0);

        // I alone at 0x10.
        clear_stats();
        set_exp(1'b0, 30'h10, 1'b1);
        I_ADDR = 30'h10; I_REQ = 1'b1;
        run_until_idle("ialone");
        check("i_first",     i_first, req_cyc + 1);
        check("i_done",      i_done_cyc, req_cyc + 8);
        check("i_done_beat", i_done_beat, 7);
        check("i_pulses",    i_cnt, 8);
        check("i_dones",     i_dones, 1);
        check("i_errs",      addr_err + data_err, 0);

        // D request arriving mid I burst waits for the gap.
        clear_stats();
        set_exp(1'b0, 30'h10, 1'b1);
        set_exp(1'b1, 30'h20, 1'b0);
        I_ADDR = 30'h10; I_REQ = 1'b1;
        for (int n = 0; n < 50 && i_cnt < 3; n++) tick();
        D_ADDR = 30'h20; D_WE = 1'b0; D_REQ = 1'b1;
        run_until_idle("mid");
        check("mid_d_after", d_first, i_done_cyc + 2);
        check("mid_counts",  {i_cnt[15:0], d_cnt[15:0]}, {16'd8, 16'd8});
        check("mid_errs",    addr_err + data_err, 0);

        // Reset at beat 3 aborts; memValid in IDLE is ignored.
        clear_stats();
        set_exp(1'b0, 30'h10, 1'b1);
        I_ADDR = 30'h10; I_REQ = 1'b1;
        for (int n = 0; n < 50 && BEAT != 3'd3; n++) tick();
        check("rst_mid_beat3", {29'd0, BEAT}, 32'd3);
        MEM_RESET = 1'b1; I_REQ = 1'b0;
        tick();
        check("rst_mid_strobes", {30'd0, MEM_RE, MEM_WE}, 32'd0);
        check("rst_mid_beat",    {29'd0, BEAT}, 32'd0);
        check("rst_mid_addr",    {2'd0, MEM_ADDR}, 32'd0);
        check("rst_mid_nodone",  i_dones, 0);
        MEM_RESET = 1'b0; mv_force = 1'b1;
        tick(); tick(); tick();
        mv_force = 1'b0;
        check("late_vld_cnt", i_cnt, 4);
        check("late_vld_idle", idle_err, 0);
        tick();

        // Ten-cycle stall per word.
        clear_stats();
        delay = 10;
        set_exp(1'b0, 30'h10, 1'b1);
        I_ADDR = 30'h10; I_REQ = 1'b1;
        run_until_idle("stall");
        check("stall_first", i_first, req_cyc + 11);
        check("stall_done",  i_done_cyc, req_cyc + 88);
        check("stall_cycles", stall_cyc, 80);
        check("stall_hold",  hold_err, 0);
        check("stall_pulses", i_cnt, 8);
        check("stall_errs",  addr_err + data_err, 0);
        delay = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
